// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the signals between the memory arbiter, its two clients
//   (instruction fetch and the load/store path) and the byte-wide RAM port.
//   slave  : arbiter side (takes requests and RAM read data, drives the rest)
//   master : client/RAM side (drives requests and RAM read data)
//   Signals:
//     if_req/if_addr -> if_rdata/if_done              fetch client
//     mem_req/we/funct3/addr/wdata -> mem_rdata/done   load/store client
//     stallreq_if/stallreq_mem                         stall requests to pipeline
//     ram_addr/ram_dout/ram_wr, ram_din                synchronous byte RAM
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic [31:0]           if_rdata;
  logic                  if_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [2:0]            mem_funct3;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;
  logic                  stallreq_if;
  logic                  stallreq_mem;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_dout;
  logic                  ram_wr;
  logic [7:0]            ram_din;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, ram_din,
    output if_rdata, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem,
           ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, ram_din,
    input  if_rdata, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem,
           ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide synchronous RAM port between instruction fetch and
//   the load/store path. Each access runs as 1, 2 or 4 byte transfers; loads
//   are assembled little-endian and sign/zero extended. MEM has fixed priority
//   over IF and only one transaction is in flight at a time.
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : synchronous active-high reset (aborts any access, no done pulse)
//     bus  : mem_arbiter_if.slave (client handshakes, stall requests, RAM port)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, RDWAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  owner_mem_q, owner_mem_d;
  logic                  we_q, we_d;
  logic                  sext_q, sext_d;
  logic [1:0]            last_idx_q, last_idx_d;   // N-1: 0, 1 or 3
  logic [1:0]            idx_q, idx_d;             // byte index on ram_addr
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  logic [7:0]            wbyte [4];
  logic [31:0]           load_word;
  logic [31:0]           load_ext;

  // Store data split into byte lanes, lane i goes out at base+i.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wbyte[gi] = wdata_q[8*gi +: 8];
  end

  // Address bits above the RAM width are ignored (address wraps).
  if (ADDR_WIDTH < 32) begin : g_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH], bus.mem_addr[31:ADDR_WIDTH]};
  end

  // Final load word: the last byte arrives on ram_din during RDWAIT, so it is
  // merged here rather than waiting another cycle for rbuf_q.
  always_comb begin
    load_word = rbuf_q;
    load_word[{idx_q, 3'b000} +: 8] = bus.ram_din;
    case (last_idx_q)
      2'd0:    load_ext = sext_q ? {{24{load_word[7]}}, load_word[7:0]}
                                 : {24'h0, load_word[7:0]};
      2'd1:    load_ext = sext_q ? {{16{load_word[15]}}, load_word[15:0]}
                                 : {16'h0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    sext_d      = sext_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_req || bus.if_req) begin
          state_d = XFER;
          idx_d   = 2'd0;
          rbuf_d  = 32'h0;
          if (bus.mem_req) begin
            owner_mem_d = 1'b1;
            we_d        = bus.mem_we;
            base_d      = bus.mem_addr[ADDR_WIDTH-1:0];
            wdata_d     = bus.mem_wdata;
            case (bus.mem_funct3)
              3'b000:  begin last_idx_d = 2'd0; sext_d = 1'b1; end
              3'b001:  begin last_idx_d = 2'd1; sext_d = 1'b1; end
              3'b100:  begin last_idx_d = 2'd0; sext_d = 1'b0; end
              3'b101:  begin last_idx_d = 2'd1; sext_d = 1'b0; end
              // W and the unused encodings: unsigned word
              default: begin last_idx_d = 2'd3; sext_d = 1'b0; end
            endcase
          end else begin
            owner_mem_d = 1'b0;
            we_d        = 1'b0;
            base_d      = bus.if_addr[ADDR_WIDTH-1:0];
            wdata_d     = 32'h0;
            last_idx_d  = 2'd3;
            sext_d      = 1'b0;
          end
          ram_addr_d = base_d;
          ram_dout_d = wdata_d[7:0];
          ram_wr_d   = we_d;
        end
      end

      XFER: begin
        // Data for the previous address is on ram_din now.
        if (!we_q && idx_q != 2'd0) begin
          rbuf_d[{idx_q - 2'd1, 3'b000} +: 8] = bus.ram_din;
        end
        if (idx_q == last_idx_q) begin
          if (we_q) begin
            state_d    = DONE;
            mem_done_d = owner_mem_q;
            if_done_d  = ~owner_mem_q;
          end else begin
            state_d = RDWAIT;
          end
        end else begin
          idx_d      = idx_q + 2'd1;
          ram_addr_d = base_q + {{(ADDR_WIDTH-2){1'b0}}, idx_d};
          ram_dout_d = wbyte[idx_d];
          ram_wr_d   = we_q;
        end
      end

      RDWAIT: begin
        state_d = DONE;
        rbuf_d  = load_word;
        if (owner_mem_q) begin
          mem_rdata_d = load_ext;
          mem_done_d  = 1'b1;
        end else begin
          if_rdata_d = load_ext;
          if_done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      last_idx_q  <= 2'd0;
      idx_q       <= 2'd0;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      rbuf_q      <= 32'h0;
      ram_addr_q  <= '0;
      ram_dout_q  <= 8'h0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      sext_q      <= sext_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_dout     = ram_dout_q;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.if_done      = if_done_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.stallreq_if  = bus.if_req & ~if_done_q;
  assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Byte RAM model, transaction-level reference model checked every cycle,
//   and directed transactions with hand-computed results.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  mem_arbiter #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with a preload port so only this block writes the array.
  logic [7:0]    ram [MSZ];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [7:0]    pl_data = 8'h0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: no done within bound", name, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]    ref_mem [MSZ];
  bit            m_live = 0, m_post_rst = 0, m_busy = 0;
  bit            m_own_mem, m_we, m_sext;
  int            m_n, m_acc;
  logic [AW-1:0] m_base;
  logic [31:0]   m_wdata;
  logic [31:0]   e_if_rdata = 0, e_mem_rdata = 0;
  bit            e_wr, e_ifd, e_memd;
  int            k;
  logic [AW-1:0] ea;

  function automatic logic [31:0] load_value();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < m_n; i++) w = w | (32'(ref_mem[AW'(m_base + AW'(i))]) << (8 * i));
    if (m_sext && m_n == 1 && w[7])  w = w | 32'hFFFF_FF00;
    if (m_sext && m_n == 2 && w[15]) w = w | 32'hFFFF_0000;
    return w;
  endfunction

  always @(negedge clk) begin
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (m_live) begin
      e_wr = 0; e_ifd = 0; e_memd = 0;
      if (m_post_rst) begin
        chk("reset ram_addr", 32'(bus.ram_addr), 32'h0);
        chk("reset ram_dout", 32'(bus.ram_dout), 32'h0);
      end
      if (m_busy) begin
        k = cyc - m_acc;
        if (k >= 1 && k <= m_n) begin
          ea = m_base + AW'(k - 1);
          chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
          if (m_we) begin
            e_wr = 1;
            chk("ram_dout", 32'(bus.ram_dout), 32'(m_wdata[8*(k-1) +: 8]));
            ref_mem[ea] = m_wdata[8*(k-1) +: 8];
          end
        end
        if (k == m_n + (m_we ? 1 : 2)) begin
          if (m_own_mem) begin
            e_memd = 1;
            if (!m_we) e_mem_rdata = load_value();
          end else begin
            e_ifd = 1;
            e_if_rdata = load_value();
          end
          m_busy = 0;
        end
      end
      chk("ram_wr", 32'(bus.ram_wr), 32'(e_wr));
      chk("if_done", 32'(bus.if_done), 32'(e_ifd));
      chk("mem_done", 32'(bus.mem_done), 32'(e_memd));
      chk("if_rdata", bus.if_rdata, e_if_rdata);
      chk("mem_rdata", bus.mem_rdata, e_mem_rdata);
      chk("stallreq_if", 32'(bus.stallreq_if), 32'(bus.if_req & ~e_ifd));
      chk("stallreq_mem", 32'(bus.stallreq_mem), 32'(bus.mem_req & ~e_memd));
      // Arbiter is free in any non-done cycle with nothing in flight.
      if (!rst && !m_busy && !e_ifd && !e_memd && (bus.mem_req || bus.if_req)) begin
        m_busy = 1;
        m_acc  = cyc;
        if (bus.mem_req) begin
          m_own_mem = 1;
          m_we      = bus.mem_we;
          m_base    = bus.mem_addr[AW-1:0];
          m_wdata   = bus.mem_wdata;
          m_n       = (bus.mem_funct3 == 3'b000 || bus.mem_funct3 == 3'b100) ? 1 :
                      (bus.mem_funct3 == 3'b001 || bus.mem_funct3 == 3'b101) ? 2 : 4;
          m_sext    = (bus.mem_funct3 == 3'b000 || bus.mem_funct3 == 3'b001);
        end else begin
          m_own_mem = 0;
          m_we      = 0;
          m_base    = bus.if_addr[AW-1:0];
          m_wdata   = 32'h0;
          m_n       = 4;
          m_sext    = 0;
        end
      end
    end
    if (rst) begin
      m_live = 1; m_post_rst = 1; m_busy = 0;
      e_if_rdata = 32'h0; e_mem_rdata = 32'h0;
    end else begin
      m_post_rst = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int addr, input logic [7:0] data);
    @(posedge clk); #1;
    pl_addr = AW'(addr); pl_data = data; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_mem(output int dcyc, output logic [31:0] rd);
    dcyc = -1; rd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_done) begin dcyc = cyc; rd = bus.mem_rdata; break; end
    end
    if (dcyc < 0) timeout("mem_done wait");
  endtask

  task automatic wait_if(output int dcyc, output logic [31:0] rd);
    dcyc = -1; rd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.if_done) begin dcyc = cyc; rd = bus.if_rdata; break; end
    end
    if (dcyc < 0) timeout("if_done wait");
  endtask

  task automatic mem_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    int t0, d;
    @(posedge clk); #1;
    bus.mem_we = we; bus.mem_funct3 = f3; bus.mem_addr = addr; bus.mem_wdata = wd;
    bus.mem_req = 1'b1;
    t0 = cyc;
    wait_mem(d, rd);
    lat = d - t0;
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] addr, output int lat, output logic [31:0] rd);
    int t0, d;
    @(posedge clk); #1;
    bus.if_addr = addr; bus.if_req = 1'b1;
    t0 = cyc;
    wait_if(d, rd);
    lat = d - t0;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, dm, di;
    logic [31:0] rd, rdi;
    bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_funct3 = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset mem_rdata", bus.mem_rdata, 32'h0);
    chk("reset if_done", 32'(bus.if_done), 32'h0);

    // LW 0x100
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    mem_op(0, 3'b010, 32'h100, 0, lat, rd);
    $display("LW  0x100 lat %0d rdata %h", lat, rd);
    chk("LW data", rd, 32'h4433_2211);
    chk("LW latency", lat, 6);

    // LB / LBU of 0x80
    preload(32'h103, 8'h80);
    mem_op(0, 3'b000, 32'h103, 0, lat, rd);
    $display("LB  0x103 lat %0d rdata %h", lat, rd);
    chk("LB data", rd, 32'hFFFF_FF80);
    chk("LB latency", lat, 3);
    mem_op(0, 3'b100, 32'h103, 0, lat, rd);
    $display("LBU 0x103 lat %0d rdata %h", lat, rd);
    chk("LBU data", rd, 32'h0000_0080);

    // LHU / LH of 0xFF80
    preload(32'h102, 8'h80); preload(32'h103, 8'hFF);
    mem_op(0, 3'b101, 32'h102, 0, lat, rd);
    $display("LHU 0x102 lat %0d rdata %h", lat, rd);
    chk("LHU data", rd, 32'h0000_FF80);
    chk("LHU latency", lat, 4);
    mem_op(0, 3'b001, 32'h102, 0, lat, rd);
    $display("LH  0x102 lat %0d rdata %h", lat, rd);
    chk("LH data", rd, 32'hFFFF_FF80);

    // SH 0x200
    preload(32'h202, 8'h77); preload(32'h203, 8'h99);
    mem_op(1, 3'b001, 32'h200, 32'h1234_ABCD, lat, rd);
    $display("SH  0x200 lat %0d", lat);
    chk("SH latency", lat, 3);
    chk("SH byte0", 32'(ram[17'h200]), 32'hCD);
    chk("SH byte1", 32'(ram[17'h201]), 32'hAB);
    chk("SH untouched", 32'(ram[17'h202]), 32'h77);

    // Simultaneous MEM (LW 0x100) and IF (0x200)
    @(posedge clk); #1;
    bus.mem_we = 0; bus.mem_funct3 = 3'b010; bus.mem_addr = 32'h100;
    bus.if_addr = 32'h200; bus.mem_req = 1; bus.if_req = 1;
    t0 = cyc;
    wait_mem(dm, rd);
    @(posedge clk); #1;
    bus.mem_req = 0;
    wait_if(di, rdi);
    @(posedge clk); #1;
    bus.if_req = 0;
    $display("both: mem done +%0d rdata %h, if done +%0d rdata %h", dm - t0, rd, di - t0, rdi);
    chk("both mem latency", dm - t0, 6);
    chk("both mem data", rd, 32'hFF80_2211);
    chk("both if latency", di - t0, 13);
    chk("both if data", rdi, 32'h9977_ABCD);

    // SW 0x300 aborted by reset taking effect at T+3
    preload(32'h302, 8'h55); preload(32'h303, 8'h66);
    @(posedge clk); #1;
    bus.mem_we = 1; bus.mem_funct3 = 3'b010; bus.mem_addr = 32'h300;
    bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; bus.mem_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("SW 0x300 aborted by reset");
    chk("abort byte0", 32'(ram[17'h300]), 32'hEF);
    chk("abort byte1", 32'(ram[17'h301]), 32'hBE);
    chk("abort byte2", 32'(ram[17'h302]), 32'h55);
    chk("abort byte3", 32'(ram[17'h303]), 32'h66);
    if_op(32'h300, lat, rd);
    $display("IF  0x300 lat %0d rdata %h", lat, rd);
    chk("IF after reset data", rd, 32'h6655_BEEF);
    chk("IF after reset latency", lat, 6);

    // LH across the address wrap
    preload(32'h1FFFF, 8'h34); preload(32'h0, 8'h82);
    mem_op(0, 3'b001, 32'h0001_FFFF, 0, lat, rd);
    $display("LH  0x1FFFF lat %0d rdata %h", lat, rd);
    chk("LH wrap data", rd, 32'hFFFF_8234);

    // SB then a load with an unused funct3 (behaves as unsigned word)
    mem_op(1, 3'b000, 32'h400, 32'h0000_00AA, lat, rd);
    $display("SB  0x400 lat %0d", lat);
    chk("SB latency", lat, 2);
    preload(32'h401, 8'h01); preload(32'h402, 8'h02); preload(32'h403, 8'h83);
    mem_op(0, 3'b111, 32'h400, 0, lat, rd);
    $display("L?  0x400 f3=111 lat %0d rdata %h", lat, rd);
    chk("illegal f3 data", rd, 32'h8302_01AA);
    chk("illegal f3 latency", lat, 6);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
